// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the serial instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CHECK
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // A count byte of zero means a full memory image.
  function automatic int count_to_words(input logic [7:0] n, input int depth);
    return (n == 8'd0) ? depth : int'(n);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte stream -> little-endian word writes into instruction memory; holds CPU in reset while loading.
// Write pulses one cycle after a word's 4th byte; rx_ready drops only during the write cycle.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH          = 256,
  parameter int         ADDR_W         = $clog2(DEPTH),
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_wa,
  output logic [31:0]       o_wd,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_rx_ready;
  logic              r_we;
  logic [ADDR_W:0]   r_widx;
  logic [ADDR_W:0]   r_nwords;
  logic [31:0]       r_word;
  logic [1:0]        r_bidx;
  logic [7:0]        r_csum;
  logic [TO_W-1:0]   r_idle;
  logic              r_hold;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic              w_in_frame;
  logic              w_timeout;
  logic [ADDR_W:0]   w_widx_inc;

  assign w_accept   = i_rx_valid && r_rx_ready;
  assign w_in_frame = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign w_timeout  = w_in_frame && !w_accept && (r_idle == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_widx_inc = r_widx + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_rx_data == SYNC_BYTE)) w_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (w_accept)       w_next = ST_DATA;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_DATA: begin
        // Sync values here are plain data: no escaping inside a frame.
        if (w_accept && (r_bidx == 2'd3)) w_next = ST_WRITE;
        else if (w_timeout)               w_next = ST_IDLE;
      end
      ST_WRITE: begin
        w_next = (w_widx_inc == r_nwords) ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: begin
        if (w_accept || w_timeout) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake and write strobe are registered from the next state so they reset to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_ready <= 1'b0;
      r_we       <= 1'b0;
      r_widx     <= '0;
      r_nwords   <= '0;
      r_word     <= '0;
      r_bidx     <= '0;
      r_csum     <= '0;
      r_idle     <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_rx_ready <= (w_next != ST_WRITE);
      r_we       <= (w_next == ST_WRITE);

      if (w_accept || !w_in_frame) begin
        r_idle <= '0;
      end else if (!w_timeout) begin
        r_idle <= r_idle + TO_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept && (i_rx_data == SYNC_BYTE)) begin
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (w_accept) begin
            r_nwords <= (ADDR_W + 1)'(count_to_words(i_rx_data, DEPTH));
            r_widx   <= '0;
            r_csum   <= '0;
            r_bidx   <= '0;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_word[{r_bidx, 3'b000} +: 8] <= i_rx_data;
            r_csum <= r_csum ^ i_rx_data;
            r_bidx <= r_bidx + 2'd1;
          end
        end
        ST_WRITE: begin
          r_widx <= w_widx_inc;
        end
        ST_CHECK: begin
          if (w_accept) begin
            if (i_rx_data == r_csum) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Hold stays asserted on failure so a partial image never runs.
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_we       = r_we;
  assign o_wa       = r_widx[ADDR_W-1:0];
  assign o_wd       = r_word;
  assign o_cpu_hold = r_hold;
  assign o_done     = r_done;
  assign o_error    = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame stimulus with a queue-based scoreboard for writes and frame outcomes.
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int TO     = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_we(we), .o_wa(wa), .o_wd(wd),
    .o_cpu_hold(cpu_hold), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  wa;
    logic [31:0] wd;
  } wr_t;

  typedef struct packed {
    logic done;
    logic error;
    logic hold;
  } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse and every frame outcome must match the head of its queue.
  wr_t  mon_wr;
  res_t mon_res;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  always @(negedge clk) begin
    if (we) begin
      if (exp_wr.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got wa=%0h wd=%0h expected no write", wa, wd);
      end else begin
        mon_wr = exp_wr.pop_front();
        chk("write_addr", 64'(wa), 64'(mon_wr.wa));
        chk("write_data", 64'(wd), 64'(mon_wr.wd));
      end
    end
    if ((done && !prev_done) || (error && !prev_err)) begin
      if (exp_res.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_result: got done=%0b error=%0b expected none", done, error);
      end else begin
        mon_res = exp_res.pop_front();
        chk("frame_done",  64'(done),     64'(mon_res.done));
        chk("frame_error", 64'(error),    64'(mon_res.error));
        chk("frame_hold",  64'(cpu_hold), 64'(mon_res.hold));
      end
    end
    prev_done = done;
    prev_err  = error;
  end

  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      budget++;
      if (budget > 20) begin
        n_vec++; n_err++;
        $display("FAIL byte_accept_timeout: got rx_ready=0 for %0d cycles expected 1", budget);
        break;
      end
    end
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: words land at 0..n-1 in order; checksum is the XOR of every data byte.
  task automatic send_frame(input int nwords, input bit bad,
                            input bit use_first, input logic [31:0] first_w);
    logic [7:0]  cs;
    logic [31:0] w;
    wr_t         e;
    res_t        r;
    cs = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(nwords));
    for (int i = 0; i < nwords; i++) begin
      w = $urandom;
      if (use_first && i == 0) w = first_w;
      e.wa = 8'(i);
      e.wd = w;
      exp_wr.push_back(e);
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    r.done  = !bad;
    r.error = bad;
    r.hold  = bad;
    exp_res.push_back(r);
    send_byte(bad ? (cs ^ 8'h1D) : cs);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  res_t rt;

  initial begin
    #22;
    chk("reset_rx_ready", 64'(rx_ready), 64'd0);
    chk("reset_we",       64'(we),       64'd0);
    chk("reset_wa",       64'(wa),       64'd0);
    chk("reset_wd",       64'(wd),       64'd0);
    chk("reset_hold",     64'(cpu_hold), 64'd0);
    chk("reset_done",     64'(done),     64'd0);
    chk("reset_error",    64'(error),    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Junk outside a frame is swallowed.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_junk_hold", 64'(cpu_hold), 64'd0);
    chk("idle_junk_done", 64'(done),     64'd0);

    send_frame(1, 1'b0, 1'b1, 32'hE3A00013);
    send_frame(1, 1'b1, 1'b1, 32'hE3A00013);
    repeat (3) begin @(posedge clk); #1; end
    chk("bad_frame_done", 64'(done), 64'd0);

    // Sync value embedded in a data word.
    send_frame(2, 1'b0, 1'b1, 32'h11A5A522);

    // Stall mid-word until the idle timeout fires.
    send_byte(8'hA5);
    send_byte(8'h02);
    rt.done = 1'b0; rt.error = 1'b1; rt.hold = 1'b1;
    exp_res.push_back(rt);
    send_byte(8'h3C);
    send_byte(8'h5A);
    repeat (TO + 10) begin @(posedge clk); #1; end
    chk("timeout_error", 64'(error),    64'd1);
    chk("timeout_hold",  64'(cpu_hold), 64'd1);
    send_frame(3, 1'b0, 1'b0, 32'h0);

    for (int f = 0; f < 6; f++) begin
      send_frame($urandom_range(1, 6), ($urandom_range(0, 2) == 0), 1'b0, 32'h0);
    end

    // Asynchronous reset in the middle of the second word.
    send_byte(8'hA5);
    send_byte(8'h03);
    begin
      wr_t e0;
      logic [31:0] w0;
      w0 = $urandom;
      e0.wa = 8'h00;
      e0.wd = w0;
      exp_wr.push_back(e0);
      for (int b = 0; b < 4; b++) send_byte(w0[8*b +: 8]);
    end
    send_byte(8'h77);
    send_byte(8'h88);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rx_ready", 64'(rx_ready), 64'd0);
    chk("midreset_we",       64'(we),       64'd0);
    chk("midreset_wa",       64'(wa),       64'd0);
    chk("midreset_wd",       64'(wd),       64'd0);
    chk("midreset_hold",     64'(cpu_hold), 64'd0);
    chk("midreset_done",     64'(done),     64'd0);
    chk("midreset_error",    64'(error),    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    send_frame(2, 1'b0, 1'b0, 32'h0);

    // Count byte 0 means the whole memory.
    send_frame(DEPTH, 1'b0, 1'b0, 32'h0);
    repeat (5) begin @(posedge clk); #1; end
    chk("full_load_done", 64'(done),     64'd1);
    chk("full_load_hold", 64'(cpu_hold), 64'd0);

    repeat (20) begin @(posedge clk); #1; end
    chk("writes_drained",  64'(exp_wr.size()),  64'd0);
    chk("results_drained", 64'(exp_res.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
